// File: rtl/disp_arbiter_if.sv
// Display ownership bus between two clients and the arbiter.
// Clients drive requests and digit data; the arbiter returns the routed view.
interface disp_arbiter_if;
    logic [1:0]  req;
    logic [31:0] data0;
    logic [7:0]  dp0;
    logic [31:0] data1;
    logic [7:0]  dp1;
    logic [1:0]  gnt;
    logic [31:0] d_out;
    logic [7:0]  dp_out;
    logic        active;
    logic        owner;

    modport master (
        output req, data0, dp0, data1, dp1,
        input  gnt, d_out, dp_out, active, owner
    );

    modport slave (
        input  req, data0, dp0, data1, dp1,
        output gnt, d_out, dp_out, active, owner
    );
endinterface

// File: rtl/disp_arbiter.sv
// Two-client display arbiter with minimum and maximum grant tenure.
// Ties go to the client that did not hold the display most recently.
module disp_arbiter #(
    parameter int MIN_HOLD = 16,
    parameter int MAX_HOLD = 256
) (
    input  logic           clk,
    input  logic           reset,
    disp_arbiter_if.slave  bus
);
    localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HOLD - 1);
    localparam logic [CW-1:0] CNT_MIN = CW'(MIN_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t        state;
    state_t        state_n;
    state_t        oth_st;
    logic [CW-1:0] cnt;
    logic          last;
    logic          own_req;
    logic          oth_req;
    logic          entry;

    always_comb begin
        own_req = (state == OWN1) ? bus.req[1] : bus.req[0];
        oth_req = (state == OWN1) ? bus.req[0] : bus.req[1];
        oth_st  = (state == OWN1) ? OWN0 : OWN1;
        state_n = state;
        unique case (state)
            IDLE: begin
                unique case (1'b1)
                    (bus.req == 2'b11): state_n = last ? OWN0 : OWN1;
                    (bus.req == 2'b01): state_n = OWN0;
                    (bus.req == 2'b10): state_n = OWN1;
                    default:            state_n = IDLE;
                endcase
            end
            OWN0, OWN1: begin
                // Preemption outranks the owner's own request.
                if (oth_req && cnt == CNT_MAX)
                    state_n = oth_st;
                else if (!own_req && cnt >= CNT_MIN)
                    state_n = oth_req ? oth_st : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign entry = (state_n != state) && (state_n != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            last  <= 1'b1;
        end else begin
            state <= state_n;
            if (state_n != state)
                cnt <= '0;
            else if (state != IDLE && cnt != CNT_MAX)
                cnt <= cnt + CW'(1);
            if (entry)
                last <= (state_n == OWN1);
        end
    end

    always_comb begin
        bus.gnt    = 2'b00;
        bus.d_out  = '0;
        bus.dp_out = '0;
        bus.active = 1'b0;
        bus.owner  = 1'b0;
        unique case (state)
            OWN0: begin
                bus.gnt    = 2'b01;
                bus.d_out  = bus.data0;
                bus.dp_out = bus.dp0;
                bus.active = 1'b1;
            end
            OWN1: begin
                bus.gnt    = 2'b10;
                bus.d_out  = bus.data1;
                bus.dp_out = bus.dp1;
                bus.active = 1'b1;
                bus.owner  = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_disp_arbiter.sv
// Bench for disp_arbiter: directed scenarios plus randomized traffic
// compared against a tenure-level reference model.
module tb_disp_arbiter;
    localparam int MINH = 4;
    localparam int MAXH = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    disp_arbiter_if bus();

    disp_arbiter #(
        .MIN_HOLD(MINH),
        .MAX_HOLD(MAXH)
    ) dut (
        .clk(clk),
        .reset(rst),
        .bus(bus)
    );

    // Reference: owner index (-1 idle), cycles held so far, last winner.
    int m_own;
    int m_held;
    int m_last;
    int m_nxt;

    function automatic int next_owner(int own, int held, int last,
                                      logic [1:0] r);
        int oth;
        if (own < 0) begin
            if (r == 2'b11) return 1 - last;
            if (r == 2'b01) return 0;
            if (r == 2'b10) return 1;
            return -1;
        end
        oth = 1 - own;
        if (r[oth] && held >= MAXH - 1) return oth;
        if (!r[own] && held >= MINH - 1) return r[oth] ? oth : -1;
        return own;
    endfunction

    always_comb m_nxt = next_owner(m_own, m_held, m_last, bus.req);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_own  <= -1;
            m_held <= 0;
            m_last <= 1;
        end else if (m_nxt != m_own) begin
            m_own  <= m_nxt;
            m_held <= 0;
            if (m_nxt >= 0) m_last <= m_nxt;
        end else if (m_own >= 0) begin
            m_held <= m_held + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        bus.req = 2'b00;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.req = 2'b11;
        bus.data0 = 32'hdeadbeef;
        bus.dp0 = 8'hff;
        bus.data1 = 32'hcafef00d;
        bus.dp1 = 8'h55;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (bus.gnt !== 2'b00 || bus.active !== 1'b0 ||
                bus.d_out !== 32'h0 || bus.dp_out !== 8'h0 ||
                bus.owner !== 1'b0) begin
                $display("FAIL reset cyc%0d: got gnt=%b act=%b d=%h dp=%h own=%b want 00/0/0/0/0",
                         i, bus.gnt, bus.active, bus.d_out, bus.dp_out,
                         bus.owner);
            end else passed++;
        end
        bus.req = 2'b00;
        rst = 1'b1;
    endtask

    task automatic test_single_pulse();
        apply_reset();
        bus.req = 2'b01;
        tick();
        bus.req = 2'b00;
        for (int k = 1; k <= 5; k++) begin
            logic [1:0] want;
            want = (k <= MINH) ? 2'b01 : 2'b00;
            total++;
            if (bus.gnt !== want)
                $display("FAIL pulse k=%0d: got gnt=%b want %b",
                         k, bus.gnt, want);
            else passed++;
            if (k < 5) tick();
        end
    endtask

    task automatic test_tie_rotation();
        apply_reset();
        bus.req = 2'b11;
        for (int k = 1; k <= 17; k++) begin
            logic [1:0] want;
            tick();
            want = (k <= 8 || k == 17) ? 2'b01 : 2'b10;
            total++;
            if (bus.gnt !== want)
                $display("FAIL tie k=%0d: got gnt=%b want %b",
                         k, bus.gnt, want);
            else passed++;
        end
        bus.req = 2'b00;
    endtask

    task automatic test_no_competition();
        int bad;
        apply_reset();
        bus.req = 2'b01;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus.gnt !== 2'b01) bad++;
        end
        total++;
        if (bad != 0)
            $display("FAIL hold_alone: got %0d non-01 cycles want 0", bad);
        else passed++;
        bus.req = 2'b11;
        tick();
        total++;
        if (bus.gnt !== 2'b10)
            $display("FAIL sat_preempt: got gnt=%b want 10", bus.gnt);
        else passed++;
        bus.req = 2'b00;
    endtask

    task automatic test_data_routing();
        apply_reset();
        bus.data0 = 32'h12345678;
        bus.dp0 = 8'h81;
        bus.data1 = 32'h9abcdef0;
        bus.dp1 = 8'h3c;
        bus.req = 2'b01;
        tick();
        bus.req = 2'b00;
        total++;
        if (bus.d_out !== 32'h12345678 || bus.dp_out !== 8'h81 ||
            bus.owner !== 1'b0 || bus.active !== 1'b1)
            $display("FAIL route0: got d=%h dp=%h own=%b act=%b want 12345678/81/0/1",
                     bus.d_out, bus.dp_out, bus.owner, bus.active);
        else passed++;
        repeat (MINH) tick();
        total++;
        if (bus.d_out !== 32'h0 || bus.dp_out !== 8'h0 ||
            bus.active !== 1'b0)
            $display("FAIL route_idle: got d=%h dp=%h act=%b want 0/0/0",
                     bus.d_out, bus.dp_out, bus.active);
        else passed++;
        bus.req = 2'b10;
        tick();
        total++;
        if (bus.d_out !== 32'h9abcdef0 || bus.dp_out !== 8'h3c ||
            bus.owner !== 1'b1 || bus.gnt !== 2'b10)
            $display("FAIL route1: got d=%h dp=%h own=%b gnt=%b want 9abcdef0/3c/1/10",
                     bus.d_out, bus.dp_out, bus.owner, bus.gnt);
        else passed++;
        bus.req = 2'b00;
        repeat (MINH) tick();
    endtask

    task automatic test_async_reset();
        apply_reset();
        bus.req = 2'b10;
        tick();
        tick();
        total++;
        if (bus.gnt !== 2'b10)
            $display("FAIL ar_own1: got gnt=%b want 10", bus.gnt);
        else passed++;
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (bus.gnt !== 2'b00 || bus.active !== 1'b0 ||
            bus.d_out !== 32'h0)
            $display("FAIL ar_abort: got gnt=%b act=%b d=%h want 00/0/0",
                     bus.gnt, bus.active, bus.d_out);
        else passed++;
        bus.req = 2'b11;
        #2;
        rst = 1'b1;
        tick();
        total++;
        if (bus.gnt !== 2'b01)
            $display("FAIL ar_first: got gnt=%b want 01", bus.gnt);
        else passed++;
        bus.req = 2'b00;
    endtask

    task automatic test_random();
        int errs;
        logic [1:0]  eg;
        logic [31:0] ed;
        logic [7:0]  ep;
        apply_reset();
        errs = 0;
        for (int k = 0; k < 600; k++) begin
            for (int b = 0; b < 2; b++)
                if ($urandom_range(0, 5) == 0) bus.req[b] = ~bus.req[b];
            bus.data0 = $urandom;
            bus.dp0 = 8'($urandom);
            bus.data1 = $urandom;
            bus.dp1 = 8'($urandom);
            tick();
            eg = (m_own == 0) ? 2'b01 : (m_own == 1) ? 2'b10 : 2'b00;
            ed = (m_own == 0) ? bus.data0 : (m_own == 1) ? bus.data1 : '0;
            ep = (m_own == 0) ? bus.dp0 : (m_own == 1) ? bus.dp1 : '0;
            total++;
            if (bus.gnt !== eg || bus.d_out !== ed || bus.dp_out !== ep ||
                bus.active !== (m_own >= 0) || bus.owner !== (m_own == 1)) begin
                errs++;
                if (errs <= 5)
                    $display("FAIL rand k=%0d: got gnt=%b d=%h dp=%h own=%b want gnt=%b d=%h dp=%h",
                             k, bus.gnt, bus.d_out, bus.dp_out, bus.owner,
                             eg, ed, ep);
            end else passed++;
        end
        bus.req = 2'b00;
    endtask

    initial begin
        bus.req = 2'b00;
        bus.data0 = '0;
        bus.dp0 = '0;
        bus.data1 = '0;
        bus.dp1 = '0;
        test_reset();
        test_single_pulse();
        test_tie_rotation();
        test_no_competition();
        test_data_routing();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/disp_arbiter.md
DISP_ARBITER -- requirements
Module: disp_arbiter

Interface
REQ-001 Parameter MIN_HOLD, default 16: minimum number of cycles a grant is held once issued; the legal range is 1 <= MIN_HOLD <= MAX_HOLD.
REQ-002 Parameter MAX_HOLD, default 256: maximum number of grant cycles while the other client is requesting.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port req, input, 2 bits: req[i] high means client i requests display ownership.
REQ-006 Port data0, input, 32 bits: client 0 digit nibbles; [31:28] = digit 7 down to [3:0] = digit 0.
REQ-007 Port dp0, input, 8 bits: client 0 decimal points; bit i = digit i.
REQ-008 Port data1, input, 32 bits: client 1 digit nibbles, same packing as data0.
REQ-009 Port dp1, input, 8 bits: client 1 decimal points, same packing as dp0.
REQ-010 Port gnt, output, 2 bits: registered grant, one-hot or zero.
REQ-011 Port d_out, output, 32 bits: nibbles routed to the display controller digit inputs.
REQ-012 Port dp_out, output, 8 bits: routed to the display controller decimal-point inputs.
REQ-013 Port active, output, 1 bit: high whenever gnt != 2'b00.
REQ-014 Port owner, output, 1 bit: index of the current grantee; 0 when idle.

Function
REQ-015 The FSM SHALL have states IDLE, OWN0 and OWN1; gnt SHALL be 01 in OWN0, 10 in OWN1 and 00 in IDLE; gnt SHALL never be 11.
REQ-016 A register `last` SHALL hold the most recently granted client; reset value 1, so client 0 wins the first tie.
REQ-017 In IDLE, a single request SHALL grant that client on the next edge (gnt rises one cycle after req is seen).
REQ-018 In IDLE with both requests asserted, the client != last SHALL be granted.
REQ-019 Tenure counter cnt SHALL be 0 in the first grant cycle, increment by 1 per cycle in OWNx, and saturate at MAX_HOLD-1.
REQ-020 Counter width SHALL be $clog2(MAX_HOLD) bits, minimum 1.
REQ-021 Release: in OWNx, if req[x]=0 and cnt >= MIN_HOLD-1, the next state SHALL be OWN(other) when req[other]=1, else IDLE.
REQ-022 If req[x] drops before MIN_HOLD cycles, the grant SHALL be held until cnt = MIN_HOLD-1, then released per REQ-021.
REQ-023 Preemption: in OWNx, if req[other]=1 and cnt = MAX_HOLD-1, the next state SHALL be OWN(other) regardless of req[x].
REQ-024 Handoff OWN0<->OWN1 SHALL occur on a single edge: old gnt bit falls and new gnt bit rises together, with no IDLE cycle.
REQ-025 On every entry to OWNx, cnt SHALL reset to 0 and last SHALL be set to x.
REQ-026 With no competing request, a client SHALL keep the grant indefinitely; cnt stays saturated and no preemption occurs.
REQ-027 d_out/dp_out SHALL equal data0/dp0 in OWN0 and data1/dp1 in OWN1, combinationally from the registered state.
REQ-028 d_out/dp_out SHALL be all-zero in IDLE.
REQ-029 owner SHALL be 1 only in OWN1.

Reset
REQ-030 When reset is low, state SHALL go to IDLE asynchronously: gnt=00, cnt=0, last=1, active=0, owner=0, d_out=0, dp_out=0.
REQ-031 A reset asserted mid-tenure SHALL abort the grant immediately, without waiting for MIN_HOLD.
REQ-032 After reset deasserts, the first grant SHALL follow REQ-017 and REQ-018.

Verification (MIN_HOLD=4, MAX_HOLD=8)
REQ-033 reset low with req=11 -> gnt=00, active=0, d_out=0 throughout.
REQ-034 req=01 for 1 cycle -> gnt=01 for exactly 4 cycles starting 1 cycle later, then 00.
REQ-035 req=11 held constantly from idle -> gnt=01 for 8 cycles, then 10 for 8 cycles, then 01; no 00 or 11 cycle in between.
REQ-036 req=01 held 20 cycles, req[1]=0 -> gnt stays 01 for all cycles; asserting req[1] then preempts 8 grant cycles after tenure start, or immediately if cnt is already saturated.
REQ-037 Owner 0 with data0=32'h12345678, dp0=8'h81 -> d_out=32'h12345678, dp_out=8'h81; after release to IDLE -> d_out=0, dp_out=0.
REQ-038 reset pulsed low during cycle 2 of an OWN1 tenure -> gnt=00 without waiting for a clock edge; next req=11 grants client 0.
